fifo_rd_drain: RTL and testbench

Read-side drain engine for the asynchronous FIFO. It runs entirely in the read clock domain, pops a programmed number of words from the FIFO read port and presents them on a valid/ready output stream. A 3-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle with no combinational path from `out_ready` to `fifo_rd_en`. It is the consumer counterpart to the FIFO write-side producer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rd_skid_buf.sv | 53 +++++
 rtl/fifo_rd_drain.sv | 106 ++++++++++
 tb/tb_fifo_rd_drain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO read-side drain engine
// Contents: drain_state_t FSM encoding, output buffer depth, default widths,
//           and the circular-buffer pointer increment helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

  localparam int RD_BUF_DEPTH   = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_W      = 16;

  // Pointer increment that wraps at RD_BUF_DEPTH (not a power of two).
  function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
    return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 3-entry circular output buffer with registered head
// Ports: clk, rst (sync active-high), wr_en/wr_data (tail write),
//        out_valid/out_data/out_ready (head stream), occ (entries held, 0..3).
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic                  rd_fire;

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[head];
  assign rd_fire   = out_valid && out_ready;

  // The producer never writes while full: it reserves a slot per pop in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= 2'd0;
      tail <= 2'd0;
      occ  <= 2'd0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= buf_ptr_inc(tail);
      end
      if (rd_fire) begin
        head <= buf_ptr_inc(head);
      end
      case ({wr_en, rd_fire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-domain engine popping xfer_len FIFO words onto a valid/ready stream
// Ports: rd_clk, rd_rst (sync active-high); start/xfer_len/busy/done control;
//        fifo_rd_en/fifo_rd_data/fifo_empty FIFO read port;
//        out_valid/out_data/out_ready stream; drained_count accepted-word count.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [LEN_W-1:0]      drained_count
);

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] accepted;
  logic             inflight;
  logic [1:0]       occ;
  logic             acc_fire;
  logic             start_ok;

  // The word popped last cycle arrives now and goes straight into the buffer.
  rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .wr_en     (inflight),
    .wr_data   (fifo_rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  assign acc_fire      = out_valid && out_ready;
  assign start_ok      = (state == ST_IDLE) && start && (xfer_len != '0);
  assign drained_count = accepted;

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (xfer_len != '0) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Count the in-flight pop against buffer space so a stalled consumer
        // can never cause an overflow; depends only on registered state.
        fifo_rd_en = !fifo_empty && (issued < len) &&
                     (({1'b0, occ} + {2'b00, inflight}) < 3'(RD_BUF_DEPTH));
        if (acc_fire && (accepted == len - LEN_W'(1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (start_ok) begin
        len      <= xfer_len;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (fifo_rd_en) begin
          issued <= issued + LEN_W'(1);
        end
        if ((state == ST_DRAIN) && acc_fire) begin
          accepted <= accepted + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - directed self-checking bench for fifo_rd_drain
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int LW = DEF_LEN_W;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy;
  logic          done;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [LW-1:0] drained_count;

  fifo_rd_drain #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .start         (start),
    .xfer_len      (xfer_len),
    .busy          (busy),
    .done          (done),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .drained_count (drained_count)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // FIFO model: one-cycle read latency, empty flag registered
  logic [DW-1:0] fq[$];
  int underflow = 0;

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (fq.size() == 0) underflow++;
      else fifo_rd_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor, sampled mid-cycle
  logic [DW-1:0] acc_data[$];
  int            acc_cyc[$];
  int rd_en_cnt, done_cnt, done_cyc, viol_cnt, busy_at_done;

  always @(negedge rd_clk) begin
    if (out_valid && out_ready && !rd_rst) begin
      acc_data.push_back(out_data);
      acc_cyc.push_back(cyc);
    end
    if (fifo_rd_en) rd_en_cnt++;
    if (fifo_rd_en && fifo_empty) viol_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = int'(busy);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_data.delete();
    acc_cyc.delete();
    rd_en_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    viol_cnt  = 0;
    busy_at_done = -1;
  endtask

  task automatic preload(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    tick(1);
  endtask

  task automatic pulse_start(input int len, output int s);
    start    = 1'b1;
    xfer_len = LW'(len);
    s        = cyc;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (done_cnt != 0) break;
      tick(1);
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    tick(1);
  endtask

  task automatic check_words(input string tag, input logic [DW-1:0] base, input int n);
    check({tag, "_n_words"}, acc_data.size(), n);
    for (int i = 0; i < n && i < acc_data.size(); i++)
      check($sformatf("%s_word%0d", tag, i), acc_data[i], base + DW'(i));
  endtask

  int s;

  initial begin
    clear_logs();
    tick(3);
    check("reset_outputs", {busy, done, fifo_rd_en, out_valid}, 4'b0000);
    check("reset_out_data", out_data, 0);
    check("reset_drained", drained_count, 0);
    rd_rst = 1'b0;
    tick(1);

    // Basic drain
    clear_logs();
    preload(8'h10, 8);
    out_ready = 1'b1;
    pulse_start(8, s);
    check("basic_busy_c1", busy, 1);
    check("basic_rden_c1", fifo_rd_en, 1);
    wait_done("basic", 60);
    check_words("basic", 8'h10, 8);
    for (int i = 0; i < acc_cyc.size(); i++)
      check($sformatf("basic_cyc%0d", i), acc_cyc[i], s + 3 + i);
    check("basic_done_cyc", done_cyc, s + 11);
    check("basic_busy_at_done", busy_at_done, 0);
    check("basic_drained", drained_count, 8);
    check("basic_rd_en_cnt", rd_en_cnt, 8);
    tick(2);
    check("basic_done_once", done_cnt, 1);

    // Back-pressure
    clear_logs();
    preload(8'h60, 8);
    out_ready = 1'b0;
    pulse_start(8, s);
    tick(10);
    check("bp_pops_before_release", rd_en_cnt, 3);
    check("bp_no_accept", acc_data.size(), 0);
    out_ready = 1'b1;
    wait_done("bp", 60);
    check_words("bp", 8'h60, 8);
    check("bp_rd_en_cnt", rd_en_cnt, 8);
    check("bp_drained", drained_count, 8);

    // Empty stall, one word every 5 cycles
    clear_logs();
    tick(2);
    pulse_start(4, s);
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      if ((i % 5) == 0 && i < 20) fq.push_back(8'hA0 + DW'(i / 5));
      tick(1);
    end
    check("stall_done_seen", done_cnt, 1);
    check_words("stall", 8'hA0, 4);
    check("stall_rd_en_vs_empty", viol_cnt, 0);
    if (acc_cyc.size() == 4) check("stall_done_after_last", done_cyc, acc_cyc[3] + 1);
    tick(1);

    // Zero length
    clear_logs();
    pulse_start(0, s);
    check("zero_done_next", done, 1);
    tick(2);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_no_pops", rd_en_cnt, 0);

    // Start ignored during DRAIN
    clear_logs();
    preload(8'h30, 6);
    pulse_start(4, s);
    tick(2);
    start = 1'b1; xfer_len = LW'(6);
    tick(1);
    start = 1'b0;
    wait_done("ign", 60);
    check_words("ign", 8'h30, 4);
    check("ign_drained", drained_count, 4);
    check("ign_rd_en_cnt", rd_en_cnt, 4);
    clear_logs();
    pulse_start(2, s);
    wait_done("flush", 40);
    check_words("flush", 8'h34, 2);

    // Reset mid-transfer after 3 accepts
    clear_logs();
    preload(8'h50, 8);
    pulse_start(8, s);
    tick(5);
    check("rst_accepts_before", acc_data.size(), 3);
    rd_rst = 1'b1;
    out_ready = 1'b0;
    tick(1);
    check("rst_outputs", {busy, done, fifo_rd_en, out_valid}, 4'b0000);
    check("rst_out_data", out_data, 0);
    check("rst_drained", drained_count, 0);
    rd_rst = 1'b0;
    tick(1);
    clear_logs();
    out_ready = 1'b1;
    pulse_start(2, s);
    wait_done("post_rst", 40);
    check_words("post_rst", 8'h56, 2);
    check("post_rst_drained", drained_count, 2);

    check("fifo_underflow", underflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
